// File: rtl/design_exmpl_pkg.sv
// Shared state encodings for the example design and its cycle-accurate checker.
package design_exmpl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10
    } state_t;

    localparam int unsigned A_W = 4;

endpackage

// File: rtl/design_exmpl_ref.sv
// Reference model of the checked design: mA/mE/mF datapath, T0/T1/T2 sequencer
// and a registered done pulse on the T2->T0 transition.
module design_exmpl_ref
    import design_exmpl_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output state_t         state_o,
    output logic [A_W-1:0] ma_o,
    output logic           me_o,
    output logic           mf_o,
    output logic           done_o
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [A_W-1:0] r_ma;
    logic [A_W-1:0] w_ma_nxt;
    logic           r_me;
    logic           w_me_nxt;
    logic           r_mf;
    logic           w_mf_nxt;
    logic           r_done;
    logic           w_done_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= T0;
            r_ma    <= '0;
            r_me    <= 1'b0;
            r_mf    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ma    <= w_ma_nxt;
            r_me    <= w_me_nxt;
            r_mf    <= w_mf_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ma_nxt    = r_ma;
        w_me_nxt    = r_me;
        w_mf_nxt    = r_mf;
        w_done_nxt  = 1'b0;
        case (r_state)
            T0: begin
                if (start_i) begin
                    w_ma_nxt    = '0;
                    w_mf_nxt    = 1'b0;
                    w_state_nxt = T1;
                end
            end
            T1: begin
                // Both the E capture and the exit test look at the pre-increment mA.
                w_ma_nxt = r_ma + A_W'(1);
                w_me_nxt = r_ma[2];
                if (r_ma[3] & r_ma[2]) begin
                    w_state_nxt = T2;
                end
            end
            T2: begin
                w_mf_nxt    = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = T0;
            end
            default: begin
                w_state_nxt = T0;
            end
        endcase
    end

    assign state_o = r_state;
    assign ma_o    = r_ma;
    assign me_o    = r_me;
    assign mf_o    = r_mf;
    assign done_o  = r_done;

endmodule

// File: rtl/design_exmpl_chk.sv
// Lock-step checker: runs the reference model beside the checked design and
// flags, counts and reports any divergence in A, E or F.
module design_exmpl_chk
    import design_exmpl_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       A_i4,
    input  logic             E_i,
    input  logic             F_i,
    output logic             busy_o,
    output logic             mism_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             done_o,
    output logic [CNT_W-1:0] run_cnt_o
);

    state_t         w_state;
    logic [A_W-1:0] w_ma;
    logic           w_me;
    logic           w_mf;
    logic           w_done;
    logic           w_accept;
    logic           w_cmp;

    logic             r_armed;
    logic             r_e_valid;
    logic             r_mism;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_run_cnt;

    design_exmpl_ref u_ref (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .state_o (w_state),
        .ma_o    (w_ma),
        .me_o    (w_me),
        .mf_o    (w_mf),
        .done_o  (w_done)
    );

    assign w_accept = (w_state == T0) && start_i;
    // E is meaningless until the model has spent a T1 cycle computing it.
    assign w_cmp = r_armed && ((A_i4 != w_ma) || (F_i != w_mf) ||
                               (r_e_valid && (E_i != w_me)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_armed   <= 1'b0;
            r_e_valid <= 1'b0;
            r_mism    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_run_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b1;
            end
            if (r_armed && (w_state == T1)) begin
                r_e_valid <= 1'b1;
            end
            r_mism <= w_cmp;
            if (w_cmp) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
            if (w_state == T2) begin
                r_run_cnt <= r_run_cnt + CNT_W'(1);
            end
        end
    end

    assign busy_o    = (w_state == T1) || (w_state == T2);
    assign mism_o    = r_mism;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
    assign done_o    = w_done;
    assign run_cnt_o = r_run_cnt;

endmodule

// File: tb/tb_design_exmpl_chk.sv
// Scoreboard bench for design_exmpl_chk: a run-position model predicts the
// outputs after each edge; a monitor pops and compares them.
module tb_design_exmpl_chk;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] A_i4 = '0;
    logic       E_i = 1'b0;
    logic       F_i = 1'b0;
    logic       busy_o;
    logic       mism_o;
    logic       err_o;
    logic [7:0] err_cnt_o;
    logic       done_o;
    logic [7:0] run_cnt_o;

    always #5 clk_i = ~clk_i;

    design_exmpl_chk #(.CNT_W(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .A_i4      (A_i4),
        .E_i       (E_i),
        .F_i       (F_i),
        .busy_o    (busy_o),
        .mism_o    (mism_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .done_o    (done_o),
        .run_cnt_o (run_cnt_o)
    );

    typedef struct {
        bit busy;
        bit mism;
        bit err;
        bit done;
        int ecnt;
        int rcnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // p = edges since start acceptance (0 = idle); a run lasts 15 edges.
    int       p = 0;
    bit [3:0] mA = '0;
    bit       mE = 1'b0;
    bit       mF = 1'b0;
    bit       armed = 1'b0;
    bit       ev = 1'b0;
    bit       err = 1'b0;
    int       ecnt = 0;
    int       rcnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit [3:0] a, input bit e, input bit f);
        exp_t x;
        bit   cmp;
        @(negedge clk_i);
        rst_i = r; start_i = s; A_i4 = a; E_i = e; F_i = f;
        cmp = armed && (a != mA || f != mF || (ev && e != mE));
        x.mism = 1'b0;
        x.done = 1'b0;
        if (r) begin
            p = 0; mA = '0; mE = 1'b0; mF = 1'b0;
            armed = 1'b0; ev = 1'b0; err = 1'b0; ecnt = 0; rcnt = 0;
        end else begin
            x.mism = cmp;
            if (cmp) begin
                err = 1'b1;
                if (ecnt < 255) ecnt++;
            end
            if (armed && p >= 1 && p <= 13) ev = 1'b1;
            if (p == 0) begin
                if (s) begin
                    p = 1; mA = '0; mF = 1'b0; armed = 1'b1;
                end
            end else if (p == 14) begin
                p = 0; mF = 1'b1; x.done = 1'b1; rcnt = (rcnt + 1) % 256;
            end else begin
                p++;
                mA = 4'(p - 1);
                mE = 1'(((p - 2) >> 2) & 1);
            end
        end
        x.busy = (p >= 1 && p <= 14);
        x.err  = err;
        x.ecnt = ecnt;
        x.rcnt = rcnt;
        q.push_back(x);
    endtask

    // Correct checked design: it presents exactly the model's values.
    task automatic good(input bit s, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, s, mA, mE, mF);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("busy_o", int'(busy_o), int'(x.busy));
                chk("mism_o", int'(mism_o), int'(x.mism));
                chk("err_o", int'(err_o), int'(x.err));
                chk("done_o", int'(done_o), int'(x.done));
                chk("err_cnt_o", int'(err_cnt_o), x.ecnt);
                chk("run_cnt_o", int'(run_cnt_o), x.rcnt);
            end
        end
    end

    initial begin : stimulus
        bit [3:0] a;
        bit       e;
        bit       f;
        int       guard;

        // Reset, then a single clean run; E is held wrong while still idle.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, mA, ~mE, mF);
        good(1'b1, 1);
        drive(1'b0, 1'b0, mA, ~mE, mF);
        good(1'b0, 20);

        // A stuck at zero for a whole run.
        good(1'b1, 1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 4'b0000, mE, mF);

        // Single E flip once E checking is live.
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        good(1'b1, 1);
        good(1'b0, 4);
        drive(1'b0, 1'b0, mA, ~mE, mF);
        good(1'b0, 15);

        // Reset mid-run at mA=0110, then a clean run.
        good(1'b1, 1);
        guard = 0;
        while (!(p > 0 && mA == 4'b0110) && guard < 40) begin
            good(1'b0, 1);
            guard++;
        end
        chk("reach_mA_0110", int'(mA), 6);
        drive(1'b1, 1'b0, mA, mE, mF);
        good(1'b0, 3);
        good(1'b1, 1);
        good(1'b0, 18);

        // Persistent mismatch drives err_cnt_o into saturation.
        good(1'b1, 1);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, ~mA, mE, mF);
        good(1'b0, 5);

        // Start held high: back-to-back runs.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        good(1'b1, 70);

        // Random traffic with sporadic faults and resets.
        for (int i = 0; i < 600; i++) begin
            a = mA; e = mE; f = mF;
            if ($urandom_range(0, 19) == 0) a = 4'($urandom);
            if ($urandom_range(0, 19) == 0) e = ~e;
            if ($urandom_range(0, 19) == 0) f = ~f;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, a, e, f);
        end

        good(1'b0, 2);
        repeat (3) @(posedge clk_i);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/design_exmpl_chk.md
DESIGN_EXMPL_CHK -- requirements
Module: design_exmpl_chk

Interface
REQ-001 Parameter: CNT_W, default 8, width of the error and run counters.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  the same start signal that drives the checked design.
REQ-005 A_i4  input  4  observed A register of the checked design.
REQ-006 E_i  input  1  observed E flag of the checked design.
REQ-007 F_i  input  1  observed F flag of the checked design.
REQ-008 busy_o  output  1  reference model is in state T1 or T2.
REQ-009 mism_o  output  1  one-cycle pulse marking a compare failure in the previous cycle.
REQ-010 err_o  output  1  sticky flag; set on any mismatch.
REQ-011 err_cnt_o  output  CNT_W  count of mismatching cycles; saturates at all-ones.
REQ-012 done_o  output  1  one-cycle pulse on each T2->T0 model transition.
REQ-013 run_cnt_o  output  CNT_W  count of completed runs; wraps modulo 2^CNT_W.

Function
REQ-014 The block SHALL hold a cycle-accurate reference model: 4-bit mA, plus mE, mF, and state T0/T1/T2.
REQ-015 In T0 with start_i=1, the model SHALL set mA<=0 and mF<=0, then go to T1; with start_i=0 it SHALL hold.
REQ-016 In T1, the model SHALL set mA<=mA+1 (mod 16) and mE<=mA[2] (pre-increment value).
REQ-017 In T1, the model SHALL go to T2 when mA[3]&mA[2]=1 (pre-increment); otherwise it SHALL stay in T1.
REQ-018 In T2, the model SHALL set mF<=1, go to T0, and pulse done_o.
REQ-019 start_i SHALL be ignored in T1 and T2.
REQ-020 A full run SHALL take exactly 15 edges from start acceptance to T0 and SHALL end with mA=4'b1101, mE=1, mF=1.
REQ-021 Flag armed SHALL set on the first start acceptance; no compares SHALL occur before it is set.
REQ-022 Flag e_valid SHALL set on the first T1 cycle after arming; E_i SHALL be compared only when e_valid=1.
REQ-023 Each edge, the compare SHALL be: armed & (A_i4!=mA | F_i!=mF | (e_valid & E_i!=mE)), using the values present before the edge.
REQ-024 The registered compare result SHALL drive mism_o, with latency of one cycle after the offending values are present.
REQ-025 On each mismatch, err_o SHALL set and err_cnt_o SHALL increment, holding at 2^CNT_W-1.
REQ-026 The done_o pulse and the run_cnt_o increment SHALL occur on the same edge as the T2->T0 transition.
REQ-027 If a mismatch and done_o occur together, both SHALL be reported independently.

Reset
REQ-028 rst_i=1 SHALL force: state=T0, mA=0, mE=0, mF=0, armed=0, e_valid=0, busy_o=0, mism_o=0, err_o=0, err_cnt_o=0, done_o=0, run_cnt_o=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done_o pulse, and checking SHALL not resume until the next start acceptance.
REQ-030 Reset SHALL take priority over start_i on the same edge.

Structure
REQ-031 The state encodings T0=2'b00, T1=2'b01, T2=2'b10 SHALL live in the shared include design_exmpl_pkg and be used by both the checked design and this checker.
REQ-032 The reference model SHALL be a sub-module design_exmpl_ref (state, mA, mE, mF, done); the compare and counter logic SHALL stay in the top level.

Verification
REQ-033 Run with a correct DUT: one start -> 15 edges later mA=1101, E=1, F=1; done_o pulses once; run_cnt_o=1; err_o=0.
REQ-034 Inject A_i4 stuck at 4'b0000 after start -> mism_o first rises 2 edges after acceptance; err_cnt_o increments every cycle thereafter.
REQ-035 Hold E_i wrong before the first T1 -> no error; flip E_i during T1 after e_valid=1 -> exactly one mism_o pulse.
REQ-036 Assert rst_i at model mA=0110 -> all outputs cleared next edge, no done_o; a later start completes a clean run with run_cnt_o=1.
REQ-037 Force a mismatch for 300 cycles with CNT_W=8 -> err_cnt_o saturates at 255; err_o stays 1.
REQ-038 Hold start_i=1 continuously -> back-to-back runs every 15 edges; run_cnt_o increments once per run.
